// File: rtl/ppu_palette_rgb.sv
// -----------------------------------------------------------------------------
// ppu_palette_rgb
// Upstream stage of the VGA/TMDS output path. Turns the PPU pixel stream
// (6-bit NES colour index, emphasis and greyscale bits) into 8-bit R/G/B for
// the line buffer and tracks the x/y position of every output pixel.
//
// Pipeline (fixed latency 3, one pixel per clock, no backpressure):
//   S1 : capture index (greyscale-masked), emphasis, frame_start, valid
//   S2 : synchronous read-first lookup in a 64x24 palette table
//   S3 : emphasis dimming, output registers, position counters
//
// Build option:
//   PPU_EMPHASIS_EN  defined   -> emphasis dimming applied in S3
//                    undefined -> pix_emph ignored, S3 is a plain register
// -----------------------------------------------------------------------------
module ppu_palette_rgb #(
   parameter int LINE_PIXELS = 256,
   parameter int FRAME_LINES = 240
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        pal_we,
   input  logic [5:0]  pal_addr,
   input  logic [23:0] pal_wdata,
   input  logic        pix_valid,
   input  logic [5:0]  pix_index,
   input  logic [2:0]  pix_emph,
   input  logic        pix_grey,
   input  logic        frame_start,
   output logic        rgb_valid,
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic        line_done,
   output logic        frame_done
);

   // Position limits, expressed in the 8-bit width of the position outputs.
   localparam logic [7:0] LAST_X    = 8'(LINE_PIXELS - 1);
   localparam logic [7:0] LAST_Y    = 8'(FRAME_LINES - 1);
   // Greyscale keeps only the luminance row of the NES colour index.
   localparam logic [5:0] GREY_MASK = 6'h30;

   // Emphasis dimming: c - c/4, can never underflow for an 8-bit unsigned c.
   function automatic logic [7:0] f_dim(input logic [7:0] c);
      return c - {2'b00, c[7:2]};
   endfunction

   // ---------------------------------------------------------------- S1 ----
   logic [5:0] w_s1_index;
   logic       r_s1_valid;
   logic [5:0] r_s1_index;
   logic       r_s1_fs;

   assign w_s1_index = pix_grey ? (pix_index & GREY_MASK) : pix_index;

   // S1: register the incoming pixel; reset drops anything in flight.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_index <= 6'd0;
         r_s1_fs    <= 1'b0;
      end else begin
         r_s1_valid <= pix_valid;
         if (pix_valid) begin
            r_s1_index <= w_s1_index;
            r_s1_fs    <= frame_start;
         end
      end
   end

`ifdef PPU_EMPHASIS_EN
   logic [2:0] r_s1_emph;
   logic [2:0] r_s2_emph;

   // S1/S2: emphasis bits travel alongside the pixel to S3.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_s1_emph <= 3'd0;
         r_s2_emph <= 3'd0;
      end else begin
         if (pix_valid) begin
            r_s1_emph <= pix_emph;
         end
         if (r_s1_valid) begin
            r_s2_emph <= r_s1_emph;
         end
      end
   end
`else
   // Emphasis is not used in this build; fold the port into a sink net.
   logic w_unused_emph;
   assign w_unused_emph = ^pix_emph;
`endif

   // ---------------------------------------------------------------- S2 ----
   logic [23:0] r_pal [0:63];
   logic [23:0] r_s2_rgb;
   logic        r_s2_valid;
   logic        r_s2_fs;

   // Palette table write port; contents survive reset, writes blocked in reset.
   always_ff @(posedge pclk) begin
      if (pal_we && !rst) begin
         r_pal[pal_addr] <= pal_wdata;
      end
   end

   // S2: read-first lookup (a same-edge write to the address returns old data).
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_fs    <= 1'b0;
         r_s2_rgb   <= 24'd0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_fs  <= r_s1_fs;
            r_s2_rgb <= r_pal[r_s1_index];
         end
      end
   end

   // ---------------------------------------------------------------- S3 ----
   logic [7:0] w_red;
   logic [7:0] w_green;
   logic [7:0] w_blue;

   // S3 colour path: apply emphasis dimming (or pass through).
   always_comb begin
      w_red   = r_s2_rgb[7:0];
      w_green = r_s2_rgb[15:8];
      w_blue  = r_s2_rgb[23:16];
`ifdef PPU_EMPHASIS_EN
      case (r_s2_emph)
         3'b000: begin
            w_red   = r_s2_rgb[7:0];
            w_green = r_s2_rgb[15:8];
            w_blue  = r_s2_rgb[23:16];
         end
         3'b111: begin
            w_red   = f_dim(r_s2_rgb[7:0]);
            w_green = f_dim(r_s2_rgb[15:8]);
            w_blue  = f_dim(r_s2_rgb[23:16]);
         end
         default: begin
            // A set emphasis bit protects its channel; the others are dimmed.
            w_red   = r_s2_emph[0] ? r_s2_rgb[7:0]   : f_dim(r_s2_rgb[7:0]);
            w_green = r_s2_emph[1] ? r_s2_rgb[15:8]  : f_dim(r_s2_rgb[15:8]);
            w_blue  = r_s2_emph[2] ? r_s2_rgb[23:16] : f_dim(r_s2_rgb[23:16]);
         end
      endcase
`endif
   end

   // Position of the pixel about to be emitted, and the one after it.
   logic [7:0] r_next_x;
   logic [7:0] r_next_y;
   logic [7:0] w_pos_x;
   logic [7:0] w_pos_y;
   logic       w_last_x;
   logic       w_last_y;
   logic [7:0] w_adv_x;
   logic [7:0] w_adv_y;

   // Position of the S2 pixel: frame_start forces the origin.
   always_comb begin
      if (r_s2_fs) begin
         w_pos_x = 8'd0;
         w_pos_y = 8'd0;
      end else begin
         w_pos_x = r_next_x;
         w_pos_y = r_next_y;
      end
   end

   assign w_last_x = (w_pos_x == LAST_X);
   assign w_last_y = (w_pos_y == LAST_Y);

   // Position following the S2 pixel, wrapping at line and frame ends.
   always_comb begin
      if (w_last_x) begin
         w_adv_x = 8'd0;
         if (w_last_y) begin
            w_adv_y = 8'd0;
         end else begin
            w_adv_y = w_pos_y + 8'd1;
         end
      end else begin
         w_adv_x = w_pos_x + 8'd1;
         w_adv_y = w_pos_y;
      end
   end

   logic       r_rgb_valid;
   logic [7:0] r_red;
   logic [7:0] r_green;
   logic [7:0] r_blue;
   logic [7:0] r_pix_x;
   logic [7:0] r_pix_y;
   logic       r_line_done;
   logic       r_frame_done;

   // S3: output registers and counters; outputs hold between valid pixels.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_rgb_valid  <= 1'b0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_red        <= 8'd0;
         r_green      <= 8'd0;
         r_blue       <= 8'd0;
         r_pix_x      <= 8'd0;
         r_pix_y      <= 8'd0;
         r_next_x     <= 8'd0;
         r_next_y     <= 8'd0;
      end else begin
         r_rgb_valid  <= r_s2_valid;
         r_line_done  <= r_s2_valid & w_last_x;
         r_frame_done <= r_s2_valid & w_last_x & w_last_y;
         if (r_s2_valid) begin
            r_red    <= w_red;
            r_green  <= w_green;
            r_blue   <= w_blue;
            r_pix_x  <= w_pos_x;
            r_pix_y  <= w_pos_y;
            r_next_x <= w_adv_x;
            r_next_y <= w_adv_y;
         end
      end
   end

   assign rgb_valid  = r_rgb_valid;
   assign red_out    = r_red;
   assign green_out  = r_green;
   assign blue_out   = r_blue;
   assign pix_x      = r_pix_x;
   assign pix_y      = r_pix_y;
   assign line_done  = r_line_done;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ppu_palette_rgb.sv
// -----------------------------------------------------------------------------
// Testbench for ppu_palette_rgb. A reference model (palette array, expected
// pixel queue with due cycle, position counters) predicts every output cycle;
// directed steps cover the worked examples, reset and frame_start behaviour.
// -----------------------------------------------------------------------------
module tb_ppu_palette_rgb;
   localparam int LP = 256;
   localparam int FL = 240;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        pal_we = 1'b0;
   logic [5:0]  pal_addr = 6'd0;
   logic [23:0] pal_wdata = 24'd0;
   logic        pix_valid = 1'b0;
   logic [5:0]  pix_index = 6'd0;
   logic [2:0]  pix_emph = 3'd0;
   logic        pix_grey = 1'b0;
   logic        frame_start = 1'b0;
   logic        rgb_valid;
   logic [7:0]  red_out, green_out, blue_out, pix_x, pix_y;
   logic        line_done, frame_done;

   ppu_palette_rgb #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
      .pclk(pclk), .rst(rst), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_wdata(pal_wdata), .pix_valid(pix_valid), .pix_index(pix_index),
      .pix_emph(pix_emph), .pix_grey(pix_grey), .frame_start(frame_start),
      .rgb_valid(rgb_valid), .red_out(red_out), .green_out(green_out),
      .blue_out(blue_out), .pix_x(pix_x), .pix_y(pix_y),
      .line_done(line_done), .frame_done(frame_done)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [7:0] r, g, b, x, y;
      logic       ld, fd;
      int         due;
   } exp_t;

   exp_t        q[$];
   logic [23:0] m_pal [64];
   int          nx, ny, cyc;
   logic [7:0]  last_r, last_g, last_b, last_x, last_y;
   int          n_err, n_checks;
   int          ld_cnt, fd_cnt, fd_x, fd_y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance model, check every output.
   task automatic step(input logic we, input logic [5:0] wa, input logic [23:0] wd,
                       input logic v, input logic [5:0] idx, input logic [2:0] e,
                       input logic g, input logic fs, input logic rs);
      exp_t ex;
      int cr, cg, cb, i;
      logic [2:0] e_eff;
      rst = rs; pal_we = we; pal_addr = wa; pal_wdata = wd;
      pix_valid = v; pix_index = idx; pix_emph = e; pix_grey = g; frame_start = fs;
      @(posedge pclk);
      cyc++;
      if (rs) begin
         q.delete();
         nx = 0; ny = 0;
         last_r = 8'd0; last_g = 8'd0; last_b = 8'd0; last_x = 8'd0; last_y = 8'd0;
      end else begin
         if (we) m_pal[wa] = wd;
         if (v) begin
            i  = g ? int'(idx & 6'h30) : int'(idx);
            cr = int'(m_pal[i][7:0]);
            cg = int'(m_pal[i][15:8]);
            cb = int'(m_pal[i][23:16]);
`ifdef PPU_EMPHASIS_EN
            e_eff = e;
`else
            e_eff = 3'b000;
`endif
            if (e_eff == 3'b111) begin
               cr -= cr / 4; cg -= cg / 4; cb -= cb / 4;
            end else if (e_eff != 3'b000) begin
               if (!e_eff[0]) cr -= cr / 4;
               if (!e_eff[1]) cg -= cg / 4;
               if (!e_eff[2]) cb -= cb / 4;
            end
            ex.r = 8'(cr); ex.g = 8'(cg); ex.b = 8'(cb);
            if (fs) begin nx = 0; ny = 0; end
            ex.x  = 8'(nx);
            ex.y  = 8'(ny);
            ex.ld = (nx == LP - 1);
            ex.fd = (nx == LP - 1) && (ny == FL - 1);
            nx++;
            if (nx == LP) begin nx = 0; ny = (ny + 1) % FL; end
            ex.due = cyc + 2;
            q.push_back(ex);
         end
      end
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
         ex = q.pop_front();
         chk("valid", rgb_valid, 1);
         chk("red", red_out, ex.r);
         chk("green", green_out, ex.g);
         chk("blue", blue_out, ex.b);
         chk("x", pix_x, ex.x);
         chk("y", pix_y, ex.y);
         chk("line_done", line_done, ex.ld);
         chk("frame_done", frame_done, ex.fd);
         last_r = ex.r; last_g = ex.g; last_b = ex.b; last_x = ex.x; last_y = ex.y;
      end else begin
         chk("idle_valid", rgb_valid, 0);
         chk("hold_red", red_out, last_r);
         chk("hold_green", green_out, last_g);
         chk("hold_blue", blue_out, last_b);
         chk("hold_x", pix_x, last_x);
         chk("hold_y", pix_y, last_y);
         chk("idle_ld", line_done, 0);
         chk("idle_fd", frame_done, 0);
      end
      if (rgb_valid === 1'b1 && line_done === 1'b1) ld_cnt++;
      if (rgb_valid === 1'b1 && frame_done === 1'b1) begin
         fd_cnt++; fd_x = int'(pix_x); fd_y = int'(pix_y);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pix(input logic [5:0] idx, input logic [2:0] e, input logic g, input logic fs);
      step(1'b0, 6'd0, 24'd0, 1'b1, idx, e, g, fs, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      n_err = 0; n_checks = 0; cyc = 0; nx = 0; ny = 0;
      ld_cnt = 0; fd_cnt = 0; fd_x = 0; fd_y = 0;
      for (int k = 0; k < 64; k++) m_pal[k] = 24'd0;

      // Reset state (pal_we during reset must be ignored).
      do_reset();
      step(1'b1, 6'h21, 24'hDEAD01, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_valid", rgb_valid, 0);
      chk("rst_red", red_out, 0);
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);

      // Fill the whole palette with random data.
      for (int k = 0; k < 64; k++)
         step(1'b1, 6'(k), 24'($urandom), 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 6'h21, 24'h3366FF, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 6'h20, 24'h405060, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 6'h05, 24'hAABBCC, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);

      // Basic lookup, three cycles of latency.
      pix(6'h21, 3'b000, 1'b0, 1'b0); idle(2);
      chk("ex_r", red_out, 8'hFF); chk("ex_g", green_out, 8'h66); chk("ex_b", blue_out, 8'h33);

      // Greyscale masks the index down to entry 0x20.
      pix(6'h21, 3'b000, 1'b1, 1'b0); idle(2);
      chk("grey_r", red_out, 8'h60); chk("grey_g", green_out, 8'h50); chk("grey_b", blue_out, 8'h40);

      // Emphasis examples.
      pix(6'h21, 3'b001, 1'b0, 1'b0); idle(2);
`ifdef PPU_EMPHASIS_EN
      chk("e1_r", red_out, 8'hFF); chk("e1_g", green_out, 8'h4D); chk("e1_b", blue_out, 8'h27);
`else
      chk("e1_r", red_out, 8'hFF); chk("e1_g", green_out, 8'h66); chk("e1_b", blue_out, 8'h33);
`endif
      pix(6'h21, 3'b111, 1'b0, 1'b0); idle(2);
`ifdef PPU_EMPHASIS_EN
      chk("e7_r", red_out, 8'hC0); chk("e7_g", green_out, 8'h4D); chk("e7_b", blue_out, 8'h27);
`else
      chk("e7_r", red_out, 8'hFF); chk("e7_g", green_out, 8'h66); chk("e7_b", blue_out, 8'h33);
`endif

      // Read-first: lookup of entry 5 on the same edge as its write.
      pix(6'h05, 3'b000, 1'b0, 1'b0);
      step(1'b1, 6'h05, 24'h112233, 1'b1, 6'h05, 3'b000, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("rf_old", red_out, 8'hCC);
      idle(1);
      chk("rf_new", red_out, 8'h33);

      // Random traffic with concurrent palette writes, gaps and frame_start.
      for (int k = 0; k < 400; k++)
         step(($urandom_range(0, 3) == 0), 6'($urandom), 24'($urandom),
              ($urandom_range(0, 3) != 0), 6'($urandom), 3'($urandom),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0), 1'b0);
      idle(3);

      // Reset mid-stream discards in-flight pixels.
      for (int k = 0; k < 5; k++) pix(6'($urandom), 3'd0, 1'b0, 1'b0);
      step(1'b0, 6'd0, 24'd0, 1'b1, 6'h21, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("mrst_v0", rgb_valid, 0);
      pix(6'h21, 3'd0, 1'b0, 1'b0); chk("mrst_v1", rgb_valid, 0);
      pix(6'h21, 3'd0, 1'b0, 1'b0); chk("mrst_v2", rgb_valid, 0);
      pix(6'h21, 3'd0, 1'b0, 1'b0); chk("mrst_v3", rgb_valid, 1);
      chk("mrst_x", pix_x, 0);
      idle(3);

      // frame_start at x=100 restarts the position at the origin.
      do_reset();
      for (int k = 0; k < 100; k++) pix(6'($urandom), 3'd0, 1'b0, 1'b0);
      idle(2);
      chk("pre_fs_x", pix_x, 8'd99);
      pix(6'($urandom), 3'd0, 1'b0, 1'b1); idle(2);
      chk("fs_x", pix_x, 0); chk("fs_y", pix_y, 0);
      pix(6'($urandom), 3'd0, 1'b0, 1'b0); idle(2);
      chk("after_fs_x", pix_x, 8'd1);

      // Full frame with random gaps.
      do_reset();
      ld_cnt = 0; fd_cnt = 0; fd_x = 0; fd_y = 0;
      for (int p = 0; p < LP * FL; p++) begin
         if ($urandom_range(0, 7) == 0) idle(1);
         pix(6'($urandom), 3'($urandom), 1'b0, (p == 0));
      end
      idle(3);
      chk("line_count", ld_cnt, 240);
      chk("frame_count", fd_cnt, 1);
      chk("frame_x", fd_x, 255);
      chk("frame_y", fd_y, 239);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
